// File: rtl/pdm_pkg.sv
// Shared defaults and per-channel state type for the PDM modulator array.
package pdm_pkg;

    localparam int PDM_DW = 8;
    localparam int PDM_CN = 4;

    // Per-channel state: error accumulator plus the density value latched at period start.
    typedef struct packed {
        logic [PDM_DW-1:0] acc;
        logic [PDM_DW-1:0] sh;
    } ch_state_t;

endpackage

// File: rtl/pdm_array_if.sv
// Configuration, density inputs and modulated outputs of the PDM array.
interface pdm_array_if
    import pdm_pkg::*;
#(
    parameter int DW = PDM_DW,
    parameter int CN = PDM_CN
);

    logic                   cfg_en;
    logic [DW-1:0]          cfg_rng;
    logic [CN-1:0][DW-1:0]  dat;
    logic [CN-1:0]          pdm;
    logic                   sync;

    modport master (
        output cfg_en,
        output cfg_rng,
        output dat,
        input  pdm,
        input  sync
    );

    modport slave (
        input  cfg_en,
        input  cfg_rng,
        input  dat,
        output pdm,
        output sync
    );

endinterface

// File: rtl/pdm_ch.sv
// One pulse-density channel: first-order error accumulator against period length rng.
module pdm_ch
    import pdm_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              start,
    input  logic [PDM_DW-1:0] rng,
    input  logic [PDM_DW-1:0] dat,
    output logic              pdm
);

    ch_state_t          st_reg;
    ch_state_t          st_next;
    logic               pdm_next;
    logic [PDM_DW-1:0]  v;
    logic [PDM_DW:0]    sum;

    always_comb begin
        // At period start the fresh (clamped) value is used directly, avoiding a period of latency.
        v        = start ? ((dat > rng) ? rng : dat) : st_reg.sh;
        sum      = {1'b0, st_reg.acc} + {1'b0, v};
        st_next  = st_reg;
        pdm_next = 1'b0;
        if (clr) begin
            st_next = '0;
        end else begin
            if (start) begin
                st_next.sh = v;
            end
            if (sum >= {1'b0, rng}) begin
                pdm_next   = 1'b1;
                // True difference is < rng, so the low bits alone are exact.
                st_next.acc = sum[PDM_DW-1:0] - rng;
            end else begin
                st_next.acc = sum[PDM_DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_reg <= '0;
            pdm    <= 1'b0;
        end else begin
            st_reg <= st_next;
            pdm    <= pdm_next;
        end
    end

endmodule

// File: rtl/pdm_array.sv
// Multi-channel PDM modulator: shared period counter and sync, one pdm_ch per channel.
module pdm_array
    import pdm_pkg::*;
#(
    parameter int DW = PDM_DW,
    parameter int CN = PDM_CN
) (
    input  logic        clk,
    input  logic        rstn,
    pdm_array_if.slave  bus
);

    logic [DW-1:0]  cnt_reg;
    logic [DW-1:0]  rng_reg;
    logic           act_reg;
    logic           sync_reg;
    logic           active;
    logic           restart;
    logic           start;
    logic           clr;
    logic [CN-1:0]  pdm_w;

    assign active  = bus.cfg_en && (bus.cfg_rng != '0);
    // A range change only counts as a restart if the previous cycle was already active.
    assign restart = active && act_reg && (bus.cfg_rng != rng_reg);
    assign start   = (cnt_reg == '0);
    assign clr     = !active || restart;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg  <= '0;
            rng_reg  <= '0;
            act_reg  <= 1'b0;
            sync_reg <= 1'b0;
        end else if (!active) begin
            cnt_reg  <= '0;
            act_reg  <= 1'b0;
            sync_reg <= 1'b0;
        end else if (restart) begin
            cnt_reg  <= '0;
            rng_reg  <= bus.cfg_rng;
            sync_reg <= 1'b0;
        end else begin
            cnt_reg  <= (cnt_reg == bus.cfg_rng - 1'b1) ? '0 : cnt_reg + 1'b1;
            rng_reg  <= bus.cfg_rng;
            act_reg  <= 1'b1;
            sync_reg <= start;
        end
    end

    generate
        for (genvar gi = 0; gi < CN; gi++) begin : g_ch
            pdm_ch u_ch (
                .clk   (clk),
                .rstn  (rstn),
                .clr   (clr),
                .start (start),
                .rng   (bus.cfg_rng),
                .dat   (bus.dat[gi]),
                .pdm   (pdm_w[gi])
            );
        end
    endgenerate

    assign bus.pdm  = pdm_w;
    assign bus.sync = sync_reg;

endmodule
